// File: rtl/collatz_pkg.sv
// Shared types and defaults for the Collatz iterator.
package collatz_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    localparam int unsigned DefWidth    = 16;
    localparam int unsigned DefDw       = 24;
    localparam int unsigned DefCntW     = 16;
    localparam int unsigned DefMaxSteps = 1000;

    // Largest value representable in a step counter of the given width.
    function automatic longint unsigned max_step_value(input int unsigned cnt_w);
        return (64'd1 << cnt_w) - 64'd1;
    endfunction

endpackage

// File: rtl/collatz_step.sv
// One Collatz iteration: next value, step increment and overflow, purely combinational.
module collatz_step #(
    parameter int unsigned DW        = 24,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_STEPS = 1000
) (
    input  logic [DW-1:0]    x_i,
    input  logic             mode_i,
    input  logic [CNT_W-1:0] steps_i,
    output logic [DW-1:0]    x_next_o,
    output logic [1:0]       inc_o,
    output logic             ovf_o
);

    localparam logic [CNT_W:0] MaxStepsW = (CNT_W+1)'(MAX_STEPS);

    logic [DW+1:0]  t;
    logic [DW+1:0]  t_half;
    logic [CNT_W:0] steps_plus2;
    logic           use_short;

    // Odd step: t = 3x+1 held at DW+2 bits so the overflow bits survive.
    always_comb begin
        t           = ({2'b00, x_i} << 1) + {2'b00, x_i} + (DW+2)'(1);
        t_half      = t >> 1;
        steps_plus2 = {1'b0, steps_i} + (CNT_W+1)'(2);
        // A fused step must not push the count past the limit.
        use_short   = mode_i && (steps_plus2 <= MaxStepsW);

        x_next_o = x_i;
        inc_o    = 2'd0;
        ovf_o    = 1'b0;
        if (x_i == DW'(1)) begin
            x_next_o = x_i;
            inc_o    = 2'd0;
        end else if (!x_i[0]) begin
            x_next_o = x_i >> 1;
            inc_o    = 2'd1;
        end else if (use_short) begin
            x_next_o = t_half[DW-1:0];
            inc_o    = 2'd2;
            ovf_o    = |t_half[DW+1:DW];
        end else begin
            x_next_o = t[DW-1:0];
            inc_o    = 2'd1;
            ovf_o    = |t[DW+1:DW];
        end
    end

endmodule

// File: rtl/collatz_engine.sv
// Collatz iterator with start/busy/done handshake, peak tracking and error flags.
module collatz_engine
    import collatz_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned DW        = DefDw,
    parameter int unsigned CNT_W     = DefCntW,
    parameter int unsigned MAX_STEPS = DefMaxSteps
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             st,
    input  logic [WIDTH-1:0] co,
    input  logic             mode,
    output logic [DW-1:0]    x,
    output logic             bs,
    output logic             done,
    output logic [CNT_W-1:0] steps,
    output logic [DW-1:0]    peak,
    output logic             ovf,
    output logic             tmo,
    output logic             zerr
);

    if (DW < WIDTH) begin : g_bad_dw
        $error("collatz_engine: DW must be >= WIDTH");
    end
    if (longint'(MAX_STEPS) > max_step_value(CNT_W)) begin : g_bad_max
        $error("collatz_engine: MAX_STEPS does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_STEPS);

    state_e           state_q, state_d;
    logic [DW-1:0]    x_q, x_d;
    logic [DW-1:0]    peak_q, peak_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             mode_q, mode_d;
    logic             ovf_q, ovf_d;
    logic             tmo_q, tmo_d;
    logic             zerr_q, zerr_d;

    logic [DW-1:0]    step_x;
    logic [1:0]       step_inc;
    logic             step_ovf;

    collatz_step #(
        .DW        (DW),
        .CNT_W     (CNT_W),
        .MAX_STEPS (MAX_STEPS)
    ) u_step (
        .x_i      (x_q),
        .mode_i   (mode_q),
        .steps_i  (steps_q),
        .x_next_o (step_x),
        .inc_o    (step_inc),
        .ovf_o    (step_ovf)
    );

    // Next-state: accept a seed in idle, iterate in run, pulse done in fin.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        peak_d  = peak_q;
        steps_d = steps_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        tmo_d   = tmo_q;
        zerr_d  = zerr_q;
        case (state_q)
            StIdle: begin
                if (st) begin
                    x_d     = DW'(co);
                    peak_d  = DW'(co);
                    steps_d = '0;
                    mode_d  = mode;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
                    zerr_d  = 1'b0;
                    if (co == '0) begin
                        zerr_d  = 1'b1;
                        state_d = StFin;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // Terminal checks in priority order: reached 1, timeout, overflow.
                if (x_q == DW'(1)) begin
                    state_d = StFin;
                end else if (steps_q == MaxCnt) begin
                    tmo_d   = 1'b1;
                    state_d = StFin;
                end else if (step_ovf) begin
                    ovf_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    x_d     = step_x;
                    steps_d = steps_q + CNT_W'(step_inc);
                    if (step_x > peak_q) begin
                        peak_d = step_x;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            peak_q  <= '0;
            steps_q <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            zerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            peak_q  <= peak_d;
            steps_q <= steps_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            zerr_q  <= zerr_d;
        end
    end

    // Busy only while iterating; the fin cycle reports done with busy low.
    always_comb begin
        bs    = (state_q == StRun);
        done  = (state_q == StFin);
        x     = x_q;
        peak  = peak_q;
        steps = steps_q;
        ovf   = ovf_q;
        tmo   = tmo_q;
        zerr  = zerr_q;
    end

endmodule
